meas_seq: RTL and testbench
===========================

# meas_seq

Measurement sequencer for the dual-counter clock-measurement path. It waits for a stable PLL lock, clears both free-running counters, then opens an enable gate for a fixed number of `CLK100MHZ` cycles. After a settle interval it latches both counter values into result registers for the hex display. It sits in the `CLK100MHZ` domain between the PLL lock output, the two `counter` instances (driving their `en`/`rst`) and `cnt2hex` (feeding its value inputs).

## Interface
- `CNT_W`, 34, width of counter values and results
- `GATE_CYCLES`, 100_000_000, gate-open length in clk cycles (≥1)
- `LOCK_WAIT`, 1024, consecutive locked cycles required before measuring (≥1)
- `CLR_CYCLES`, 4, counter-clear pulse length (≥1)
- `SETTLE`, 8, cycles between gate close and latch, so counter outputs are quasi-static (≥1)
- `TOL`, 16, mismatch tolerance (used only with `MEAS_SEQ_CMP_EN`)

Ports:
- `clk` in 1: system clock, `CLK100MHZ`
- `rst` in 1: synchronous, active-high reset
- `start_i` in 1: measurement request, level-sampled
- `cont_i` in 1: continuous mode; restart automatically after each result
- `pll_locked_i` in 1: PLL LOCKED, already synchronized to `clk`
- `cnt_val_1_i`, `cnt_val_2_i` in `CNT_W`: counter outputs
- `cnt_clr_o` out 1: counter reset
- `cnt_en_o` out 1: counter enable (gate)
- `res_1_o`, `res_2_o` out `CNT_W`: latched results
- `done_o` out 1: one-cycle pulse when new results are valid
- `busy_o` out 1: high in any state other than IDLE
- `err_o` out 1: sticky; lock was lost mid-measurement

## Operation
- States: IDLE, LOCKW, CLEAR, GATE, SETTLE, LATCH.
- IDLE: if `start_i`=1, go to LOCKW. `err_o` clears on the same edge.
- LOCKW: the lock counter increments while `pll_locked_i`=1 and resets to 0 when it is 0. After `LOCK_WAIT` consecutive locked cycles, go to CLEAR. There is no timeout.
- CLEAR: `cnt_clr_o`=1 for exactly `CLR_CYCLES` cycles, then GATE.
- GATE: `cnt_en_o`=1 for exactly `GATE_CYCLES` cycles, then SETTLE.
- SETTLE: `SETTLE` idle cycles, then LATCH.
- LATCH: one cycle. `res_1_o`/`res_2_o` load from the inputs on the exiting edge and `done_o` pulses in the following cycle.
  - Exit goes to LOCKW if `cont_i`=1 or `start_i`=1, otherwise to IDLE.
- Lock loss: `pll_locked_i`=0 in CLEAR, GATE or SETTLE → IDLE on the next edge.
  - `err_o` is set.
  - `cnt_en_o`/`cnt_clr_o` drop.
  - Results are not updated and `done_o` does not pulse.
- `start_i` is ignored while busy, except as a restart request at LATCH.
- A single down-counter of width `$clog2(max param)+1` is shared by the timed states and reloaded on each state entry.

## Timing
- Reset values:
  - state IDLE
  - `cnt_clr_o`=1 (counters held clear during reset)
  - `cnt_en_o`=0, `done_o`=0, `busy_o`=0, `err_o`=0
  - `res_1_o`=`res_2_o`=0
- All outputs are registered, with no combinational input-to-output paths.
- In IDLE `cnt_clr_o`=0 after reset releases.
- Latency from the `start_i` sampling edge to `done_o`, with lock held high: 1+`LOCK_WAIT`+`CLR_CYCLES`+`GATE_CYCLES`+`SETTLE`+1 cycles.
- `rst` asserted mid-operation returns to reset values on the next edge, regardless of state.
- Results stay stable between `done_o` pulses.

## Configuration
- `MEAS_SEQ_CMP_EN` defined adds the following outputs:
  - `diff_o` out `CNT_W+1`: signed `res_1_o`−`res_2_o`, registered and updated together with the results
  - `mismatch_o` out 1: |`diff_o`| > `TOL`, updated in the same cycle as `diff_o`
  - Reset value of both is 0.
- Undefined: these ports and their logic do not exist.

## Test plan
Parameters for all scenarios: `LOCK_WAIT`=4, `CLR_CYCLES`=2, `GATE_CYCLES`=10, `SETTLE`=2.
- Lock held, `start_i` pulsed at cycle 0:
  - `cnt_clr_o` high cycles 5–6 and `cnt_en_o` high cycles 7–16.
  - `done_o` pulses at cycle 20 with results equal to the input values at cycle 19.
- Lock toggles low at the 3rd LOCKW cycle → `LOCK_WAIT` restarts; `done_o` is delayed by 3 cycles (23).
- Lock dropped at GATE cycle 5:
  - Next cycle: IDLE, `err_o`=1, `cnt_en_o`=0.
  - Results unchanged and no `done_o`.
  - The next `start_i` clears `err_o`.
- `cont_i`=1 → `done_o` pulses periodically every 20 cycles with no `start_i` after the first.
- `rst` pulsed during GATE → all outputs return to reset values next cycle, including `res_*_o`=0.
- With `MEAS_SEQ_CMP_EN`, `TOL`=16, inputs 1000/980 → `diff_o`=20, `mismatch_o`=1. Inputs 1000/990 → `diff_o`=10, `mismatch_o`=0.

Source files
------------

// File: rtl/meas_seq.sv
// Measurement sequencer: waits for stable PLL lock, clears the counters, gates them
// for a fixed window, settles, then latches both counts. Optional compare outputs: MEAS_SEQ_CMP_EN.
module meas_seq #(
    parameter int CNT_W       = 34,
    parameter int GATE_CYCLES = 100_000_000,
    parameter int LOCK_WAIT   = 1024,
    parameter int CLR_CYCLES  = 4,
    parameter int SETTLE      = 8
`ifdef MEAS_SEQ_CMP_EN
    ,
    parameter int TOL         = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             pll_locked_i,
    input  logic [CNT_W-1:0] cnt_val_1_i,
    input  logic [CNT_W-1:0] cnt_val_2_i,
    output logic             cnt_clr_o,
    output logic             cnt_en_o,
    output logic [CNT_W-1:0] res_1_o,
    output logic [CNT_W-1:0] res_2_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o
`ifdef MEAS_SEQ_CMP_EN
    ,
    output logic signed [CNT_W:0] diff_o,
    output logic                  mismatch_o
`endif
);

    localparam int MAX_AB = (GATE_CYCLES > LOCK_WAIT) ? GATE_CYCLES : LOCK_WAIT;
    localparam int MAX_CD = (CLR_CYCLES > SETTLE) ? CLR_CYCLES : SETTLE;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TW     = $clog2(MAX_P) + 1;

    // LOCKW loads the full count: the cycle that sees zero is the extra transition cycle.
    localparam logic [TW-1:0] LW_LD   = TW'(LOCK_WAIT);
    localparam logic [TW-1:0] CLR_LD  = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LD = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] ST_LD   = TW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOCKW, S_CLEAR, S_GATE, S_SETTLE, S_LATCH
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer, timer_next;
    logic          lock_loss;

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        timer_next = timer;
        lock_loss  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    next_state = S_LOCKW;
                    timer_next = LW_LD;
                end
            end
            S_LOCKW: begin
                if (timer == '0) begin
                    next_state = S_CLEAR;
                    timer_next = CLR_LD;
                end else if (!pll_locked_i) begin
                    timer_next = LW_LD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_CLEAR: begin
                if (!pll_locked_i) begin
                    lock_loss  = 1'b1;
                    next_state = S_IDLE;
                end else if (timer == '0) begin
                    next_state = S_GATE;
                    timer_next = GATE_LD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_GATE: begin
                if (!pll_locked_i) begin
                    lock_loss  = 1'b1;
                    next_state = S_IDLE;
                end else if (timer == '0) begin
                    next_state = S_SETTLE;
                    timer_next = ST_LD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_SETTLE: begin
                if (!pll_locked_i) begin
                    lock_loss  = 1'b1;
                    next_state = S_IDLE;
                end else if (timer == '0) begin
                    next_state = S_LATCH;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            S_LATCH: begin
                if (cont_i || start_i) begin
                    next_state = S_LOCKW;
                    timer_next = LW_LD;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef MEAS_SEQ_CMP_EN
    logic signed [CNT_W:0] diff_calc;
    logic [CNT_W:0]        diff_mag;

    always_comb begin
        diff_calc = $signed({1'b0, cnt_val_1_i}) - $signed({1'b0, cnt_val_2_i});
        diff_mag  = diff_calc[CNT_W] ? $unsigned(-diff_calc) : $unsigned(diff_calc);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            cnt_clr_o <= 1'b1;
            cnt_en_o  <= 1'b0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            res_1_o   <= '0;
            res_2_o   <= '0;
`ifdef MEAS_SEQ_CMP_EN
            diff_o     <= '0;
            mismatch_o <= 1'b0;
`endif
        end else begin
            state     <= next_state;
            timer     <= timer_next;
            // Outputs decode the next state so they are registered yet aligned with it.
            cnt_clr_o <= (next_state == S_CLEAR);
            cnt_en_o  <= (next_state == S_GATE);
            busy_o    <= (next_state != S_IDLE);
            done_o    <= (state == S_LATCH);
            if (lock_loss)
                err_o <= 1'b1;
            else if (state == S_IDLE && start_i)
                err_o <= 1'b0;
            if (state == S_LATCH) begin
                res_1_o <= cnt_val_1_i;
                res_2_o <= cnt_val_2_i;
`ifdef MEAS_SEQ_CMP_EN
                diff_o     <= diff_calc;
                mismatch_o <= (diff_mag > (CNT_W+1)'(TOL));
`endif
            end
        end
    end

endmodule

// File: tb/tb_meas_seq.sv
// Scoreboard bench for meas_seq: stimulus pushes the expected done cycle, a negedge
// monitor compares done timing and latched results against the recorded input history.
module tb_meas_seq;

    localparam int CNT_W = 34;
    localparam int LW    = 4;
    localparam int CLR   = 2;
    localparam int GATE  = 10;
    localparam int SET   = 2;
    localparam int TOLV  = 16;

    logic             clk = 1'b0;
    logic             rst, start_i, cont_i, pll_locked_i;
    logic [CNT_W-1:0] cnt_val_1_i, cnt_val_2_i;
    logic             cnt_clr_o, cnt_en_o, done_o, busy_o, err_o;
    logic [CNT_W-1:0] res_1_o, res_2_o;
`ifdef MEAS_SEQ_CMP_EN
    logic signed [CNT_W:0] diff_o;
    logic                  mismatch_o;
`endif

    meas_seq #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .LOCK_WAIT(LW),
        .CLR_CYCLES(CLR), .SETTLE(SET)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i),
        .pll_locked_i(pll_locked_i),
        .cnt_val_1_i(cnt_val_1_i), .cnt_val_2_i(cnt_val_2_i),
        .cnt_clr_o(cnt_clr_o), .cnt_en_o(cnt_en_o),
        .res_1_o(res_1_o), .res_2_o(res_2_o),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
`ifdef MEAS_SEQ_CMP_EN
        , .diff_o(diff_o), .mismatch_o(mismatch_o)
`endif
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    int               cyc    = 0;
    int               exp_q[$];
    logic [CNT_W-1:0] hist1 [0:4095];
    logic [CNT_W-1:0] hist2 [0:4095];
    logic [CNT_W-1:0] model_r1 = '0;
    logic [CNT_W-1:0] model_r2 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle and present fresh random counter values, recording them.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cnt_val_1_i = CNT_W'({$urandom(), $urandom()});
        cnt_val_2_i = CNT_W'({$urandom(), $urandom()});
        hist1[cyc]  = cnt_val_1_i;
        hist2[cyc]  = cnt_val_2_i;
    endtask

    // Results come from the inputs seen in the cycle just before the done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                int d;
                d = exp_q.pop_front();
                check("done_pulse", done_o, 1);
                check("res_1", res_1_o, hist1[d-1]);
                check("res_2", res_2_o, hist2[d-1]);
                model_r1 = hist1[d-1];
                model_r2 = hist2[d-1];
`ifdef MEAS_SEQ_CMP_EN
                begin
                    longint dv, mag;
                    dv  = longint'(hist1[d-1]) - longint'(hist2[d-1]);
                    mag = (dv < 0) ? -dv : dv;
                    check("diff", 64'(diff_o), 64'(dv));
                    check("mismatch", mismatch_o, (mag > TOLV));
                end
`endif
            end else if (done_o) begin
                check("done_unexpected", done_o, 0);
            end
        end
    end

    // One transaction with lock held except an optional glitch at LOCKW offset j.
    // Lock counting restarts after the last low cycle; LATCH follows LOCK_WAIT+1 LOCKW cycles.
    task automatic run_txn(input int j, input bit fix,
                           input logic [CNT_W-1:0] v1, input logic [CNT_W-1:0] v2);
        int s, g, dc;
        step();
        start_i = 1'b1;
        s  = cyc + 1;
        g  = (j < 0) ? s - 1 : s + j;
        dc = g + 1 + LW + 1 + CLR + GATE + SET + 1;
        exp_q.push_back(dc);
        while (cyc < dc + 1) begin
            step();
            start_i      = 1'b0;
            pll_locked_i = !(j >= 0 && cyc == s + j);
            if (fix && cyc == dc - 1) begin
                cnt_val_1_i = v1;
                cnt_val_2_i = v2;
                hist1[cyc]  = v1;
                hist2[cyc]  = v2;
            end
        end
    endtask

    initial begin
        int s;
        rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; pll_locked_i = 1'b1;
        cnt_val_1_i = '0; cnt_val_2_i = '0;
        step(); step();
        @(negedge clk);
        check("rst_clr", cnt_clr_o, 1);
        check("rst_en", cnt_en_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_res", {res_1_o, res_2_o}, 0);
        rst = 1'b0;
        step();
        @(negedge clk);
        check("idle_clr", cnt_clr_o, 0);

        // Basic run with windows checked cycle by cycle; a start during GATE is ignored.
        step();
        start_i = 1'b1;
        s = cyc + 1;
        exp_q.push_back(s + 20);
        @(negedge clk);
        while (cyc < s + 21) begin
            int r;
            step();
            r = cyc - s;
            start_i = (r == 10);
            @(negedge clk);
            check("clr_win", cnt_clr_o, (r >= 5 && r <= 6));
            check("en_win", cnt_en_o, (r >= 7 && r <= 16));
            check("busy_win", busy_o, (r >= 0 && r <= 19));
        end

        // Randomised runs, some with a lock glitch during lock wait.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) step();
            run_txn(int'($urandom_range(0, 4)) - 1, 1'b0, '0, '0);
        end
        run_txn(2, 1'b0, '0, '0);

        // Lock dropped in the 5th GATE cycle.
        step();
        start_i = 1'b1;
        s = cyc + 1;
        while (cyc < s + 14) begin
            step();
            start_i      = 1'b0;
            pll_locked_i = (cyc != s + 11);
            if (cyc == s + 12) begin
                @(negedge clk);
                check("drop_busy", busy_o, 0);
                check("drop_err", err_o, 1);
                check("drop_en", cnt_en_o, 0);
                check("drop_res_1", res_1_o, model_r1);
                check("drop_res_2", res_2_o, model_r2);
            end
        end
        repeat (10) step();
        check("err_sticky", err_o, 1);
        step();
        start_i = 1'b1;
        s = cyc + 1;
        exp_q.push_back(s + 20);
        step();
        start_i = 1'b0;
        @(negedge clk);
        check("err_cleared", err_o, 0);
        while (cyc < s + 22) step();

        // Continuous mode: three results from a single start.
        step();
        start_i = 1'b1;
        cont_i  = 1'b1;
        s = cyc + 1;
        exp_q.push_back(s + 20);
        exp_q.push_back(s + 40);
        exp_q.push_back(s + 60);
        while (cyc < s + 64) begin
            step();
            start_i = 1'b0;
            if (cyc == s + 45) cont_i = 1'b0;
        end
        @(negedge clk);
        check("cont_stop_busy", busy_o, 0);

        // Synchronous reset in the middle of GATE.
        step();
        start_i = 1'b1;
        s = cyc + 1;
        while (cyc < s + 11) begin
            step();
            start_i = 1'b0;
            rst     = (cyc == s + 10);
        end
        @(negedge clk);
        check("mid_rst_clr", cnt_clr_o, 1);
        check("mid_rst_en", cnt_en_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_res_1", res_1_o, 0);
        check("mid_rst_res_2", res_2_o, 0);
        step();
        @(negedge clk);
        check("post_rst_clr", cnt_clr_o, 0);

`ifdef MEAS_SEQ_CMP_EN
        run_txn(-1, 1'b1, CNT_W'(1000), CNT_W'(980));
        check("diff_20", 64'(diff_o), 64'(20));
        check("mismatch_20", mismatch_o, 1);
        run_txn(-1, 1'b1, CNT_W'(1000), CNT_W'(990));
        check("diff_10", 64'(diff_o), 64'(10));
        check("mismatch_10", mismatch_o, 0);
`endif

        for (int k = 0; k < 100 && exp_q.size() > 0; k++) step();
        check("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
